// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multiply/divide sequencer for the EXE stage of the MIPS pipeline.
//
// Accepts mult/multu/div/divu from the EXE pipeline register. The full result
// is computed at the accept edge and held in a pending register. It is
// committed to HI/LO only after the operation's fixed latency has elapsed,
// which models a multi-cycle unit. mtlo/mthi write LO/HI directly while the
// unit is idle. The block also raises a stall toward the hazard unit while
// an MDU instruction in ID would collide with a busy or starting MDU.
//
// Ports:
//   clk         clock, all state on the rising edge
//   reset       synchronous active-high reset
//   Start       EXE: launch mult/multu/div/divu
//   MDU_Sel     EXE: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mtlo, 6 mthi
//   A, B        EXE: forwarded rs / rt values
//   MDU_RD_Sel  read select (0 LO, 1 HI)
//   ID_MDU_Use  ID-stage instruction uses the MDU
//   RD          selected HI/LO value (combinational)
//   HI, LO      architectural HI/LO registers
//   Busy        operation in progress
//   Stall       ID_MDU_Use & (Busy | Start) (combinational)
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDU_Sel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MDU_RD_Sel,
    input  logic        ID_MDU_Use,
    output logic [31:0] RD,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Stall
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [2:0] SEL_MULT  = 3'd1;
    localparam logic [2:0] SEL_MULTU = 3'd2;
    localparam logic [2:0] SEL_DIV   = 3'd3;
    localparam logic [2:0] SEL_DIVU  = 3'd4;
    localparam logic [2:0] SEL_MTLO  = 3'd5;
    localparam logic [2:0] SEL_MTHI  = 3'd6;

    // Full 64-bit product. Sign-extending both operands to 64 bits makes the
    // low 64 bits of the unsigned product equal to the signed product.
    function automatic logic [63:0] mul_64(input logic [31:0] a, input logic [31:0] b,
                                           input logic is_signed);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = is_signed ? {{32{a[31]}}, a} : {32'h0000_0000, a};
        eb = is_signed ? {{32{b[31]}}, b} : {32'h0000_0000, b};
        return ea * eb;
    endfunction

    // Returns {remainder, quotient}. A signed divide works on magnitudes and
    // then restores the signs: the quotient truncates toward zero and the
    // remainder follows the dividend. 0x80000000 / -1 falls out naturally
    // as quotient 0x80000000 and remainder 0. A zero divisor is replaced by 1
    // only to keep the divider well defined, because the result is discarded.
    function automatic logic [63:0] div_64(input logic [31:0] a, input logic [31:0] b,
                                           input logic is_signed);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] q;
        logic [31:0] r;
        neg_a = is_signed & a[31];
        neg_b = is_signed & b[31];
        mag_a = neg_a ? (32'd0 - a) : a;
        mag_b = neg_b ? (32'd0 - b) : b;
        if (mag_b == 32'd0) begin
            mag_b = 32'd1;
        end else begin
            mag_b = mag_b;
        end
        q = mag_a / mag_b;
        r = mag_a % mag_b;
        if (neg_a ^ neg_b) begin
            q = 32'd0 - q;
        end else begin
            q = q;
        end
        if (neg_a) begin
            r = 32'd0 - r;
        end else begin
            r = r;
        end
        return {r, q};
    endfunction

    logic [0:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [63:0]      pend_r;
    logic             pend_ok_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;

    logic             op_s;
    logic             accept_s;
    logic [CNT_W-1:0] load_s;
    logic [63:0]      res_s;
    logic             res_ok_s;

    // Decode the EXE operation and form its result and latency.
    always_comb begin
        op_s     = 1'b0;
        load_s   = MULT_LOAD;
        res_s    = 64'd0;
        res_ok_s = 1'b1;
        case (MDU_Sel)
            SEL_MULT: begin
                op_s  = 1'b1;
                res_s = mul_64(A, B, 1'b1);
            end
            SEL_MULTU: begin
                op_s  = 1'b1;
                res_s = mul_64(A, B, 1'b0);
            end
            SEL_DIV: begin
                op_s     = 1'b1;
                load_s   = DIV_LOAD;
                res_s    = div_64(A, B, 1'b1);
                res_ok_s = (B != 32'd0);
            end
            SEL_DIVU: begin
                op_s     = 1'b1;
                load_s   = DIV_LOAD;
                res_s    = div_64(A, B, 1'b0);
                res_ok_s = (B != 32'd0);
            end
            default: begin
                op_s = 1'b0;
            end
        endcase
        accept_s = (state_r == ST_IDLE) & Start & op_s;
    end

    // Sequencer, pending result, and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            pend_r    <= 64'd0;
            pend_ok_r <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r   <= ST_RUN;
                        cnt_r     <= load_s;
                        pend_r    <= res_s;
                        pend_ok_r <= res_ok_s;
                    end else if (!Start && (MDU_Sel == SEL_MTLO)) begin
                        lo_r <= A;
                    end else if (!Start && (MDU_Sel == SEL_MTHI)) begin
                        hi_r <= A;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Start and mthi/mtlo are ignored here; the stall keeps them out.
                    if (cnt_r == '0) begin
                        state_r <= ST_IDLE;
                        if (pend_ok_r) begin
                            hi_r <= pend_r[63:32];
                            lo_r <= pend_r[31:0];
                        end else begin
                            hi_r <= hi_r;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign HI    = hi_r;
    assign LO    = lo_r;
    assign Busy  = (state_r == ST_RUN);
    assign RD    = MDU_RD_Sel ? hi_r : lo_r;
    assign Stall = ID_MDU_Use & (Busy | Start);

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl -- scoreboard testbench for mdu_ctrl.
// The stimulus process drives the inputs once per cycle. It also advances a
// cycle-level reference model that uses plain integer arithmetic. When an
// operation is launched, its expected result is pushed onto a queue. A
// separate monitor runs on the falling edge. It compares the outputs every
// cycle. When Busy drops after a commit, it pops the expected result and
// checks it.
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_sel;
    logic        id_use;
    logic [31:0] rd;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .Start(start), .MDU_Sel(sel), .A(a), .B(b),
        .MDU_RD_Sel(rd_sel), .ID_MDU_Use(id_use), .RD(rd), .HI(hi), .LO(lo),
        .Busy(busy), .Stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        exp_q[$];
    int          tests  = 0;
    int          errors = 0;

    // Reference model state.
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] m_pend;
    int          m_left;
    logic        m_rst_edge;
    logic        mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result {HI,LO} of an MDU operation, from the ISA rules.
    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] x,
                                           input logic [31:0] y, input logic [63:0] cur);
        int          ix;
        int          iy;
        longint      lx;
        longint      ly;
        longint      p;
        logic [63:0] ux;
        logic [63:0] uy;
        ix = x;
        iy = y;
        lx = ix;
        ly = iy;
        ux = {32'h0, x};
        uy = {32'h0, y};
        case (op)
            3'd1: begin
                p = lx * ly;
                return p;
            end
            3'd2: return ux * uy;
            3'd3: begin
                if (y == 32'd0) return cur;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(ix % iy), 32'(ix / iy)};
            end
            3'd4: begin
                if (y == 32'd0) return cur;
                return {x % y, x / y};
            end
            default: return cur;
        endcase
    endfunction

    // One clock edge: advance the model with the inputs that were present at the edge.
    task automatic tick();
        @(posedge clk);
        m_rst_edge = reset;
        if (reset) begin
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            m_left = 0;
            exp_q.delete();
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) {m_hi, m_lo} = m_pend;
        end else if (start && sel >= 3'd1 && sel <= 3'd4) begin
            m_pend = ref_op(sel, a, b, {m_hi, m_lo});
            m_left = (sel <= 3'd2) ? MULT_N : DIV_N;
            exp_q.push_back('{m_pend[63:32], m_pend[31:0], m_left});
        end else if (!start && sel == 3'd5) begin
            m_lo = a;
        end else if (!start && sel == 3'd6) begin
            m_hi = a;
        end
        #1;
    endtask

    task automatic drive(input logic st, input logic [2:0] sl, input logic [31:0] av,
                         input logic [31:0] bv, input logic id, input logic rs);
        reset  = 1'b0;
        start  = st;
        sel    = sl;
        a      = av;
        b      = bv;
        id_use = id;
        rd_sel = rs;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 3'd0, 32'hDEAD_BEEF, 32'h0, 1'b1, i[0]);
            tick();
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        drive(1'b1, op, x, y, 1'b1, 1'b0);
        tick();
        idle(DIV_N + 2);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares the outputs every cycle and pops the scoreboard on each commit.
    int   run_len   = 0;
    logic prev_busy = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", busy, m_left != 0);
            chk("stall", stall, id_use & ((m_left != 0) | start));
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("rd", rd, rd_sel ? m_hi : m_lo);
            if (busy) begin
                run_len++;
            end else if (prev_busy) begin
                if (!m_rst_edge) begin
                    if (exp_q.size() == 0) begin
                        chk("commit_expected", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("commit_hi", hi, e.hi);
                        chk("commit_lo", lo, e.lo);
                        chk("busy_len", 64'(run_len), 64'(e.n));
                    end
                end
                run_len = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_pend = 64'd0; m_rst_edge = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        mon_en = 1'b1;
        reset = 1'b1;
        tick();
        idle(2);

        // Directed cases.
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd4, 32'd7, 32'd0);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFFF, 32'd10);
        drive(1'b0, 3'd5, 32'h0000_1234, 32'h0, 1'b0, 1'b0);
        tick();
        idle(1);
        // mthi while running must be ignored.
        drive(1'b1, 3'd1, 32'd6, 32'd7, 1'b1, 1'b1);
        tick();
        drive(1'b0, 3'd6, 32'hCAFE_0000, 32'h0, 1'b1, 1'b1);
        tick();
        idle(DIV_N);
        // Reset three cycles into a divide: no late commit.
        drive(1'b1, 3'd3, 32'd100, 32'd7, 1'b1, 1'b0);
        tick();
        idle(3);
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b1);
        reset = 1'b1;
        tick();
        idle(DIV_N + 3);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), pick(), pick(),
                  1'($urandom), 1'($urandom));
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        idle(DIV_N + 3);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
